mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between two pipeline requesters: port 0 is instruction fetch and port 1 is data load/store.
- Accepts one transaction at a time over a valid/ready handshake.
- Drives the memory for one cycle, waits a fixed read latency, then returns a one-cycle response to the requester that was granted.
- Ties are broken round-robin. Sits between the fetch/memory stages and the shared memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_rr_pick2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_MEM_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for both requesters plus the shared memory bus.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    localparam int BW = DW / 8;

    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [BW-1:0] req0_be;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [BW-1:0] req1_be;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes
// to the port that was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = PORT_FETCH;
        if (valid0 && valid1) begin
            winner = ~last_grant;
        end else if (valid1) begin
            winner = PORT_DATA;
        end
        grant    = 2'b00;
        grant[0] = valid0 && (winner == PORT_FETCH);
        grant[1] = valid1 && (winner == PORT_DATA);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (port 0) and
// load/store (port 1); one transaction in flight, round-robin on ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              clock,
    input  logic              areset,
    mem_port_arbiter_if.slave bus,
    output logic              busy
);
    localparam int            BW       = DW / 8;
    localparam int            CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    arb_state_e    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_id_q, grant_id_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DW-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic          busy_q, busy_d;
    logic [1:0]    pick_grant;
    logic          pick_winner;

    rr_pick2 u_pick (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .winner     (pick_winner)
    );

    assign bus.req0_ready = (state_q == IDLE) && pick_grant[0];
    assign bus.req1_ready = (state_q == IDLE) && pick_grant[1];
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign busy           = busy_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_be_d     = '0;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;

        case (state_q)
            IDLE: begin
                // The mem_* registers double as the latched request; they are
                // only non-zero during the ISSUE cycle that follows.
                if (|pick_grant) begin
                    grant_id_d   = pick_winner;
                    last_grant_d = pick_winner;
                    mem_en_d     = 1'b1;
                    if (pick_winner == PORT_DATA) begin
                        we_d        = bus.req1_we;
                        mem_addr_d  = bus.req1_addr;
                        mem_wdata_d = bus.req1_wdata;
                        mem_be_d    = bus.req1_be;
                    end else begin
                        we_d        = bus.req0_we;
                        mem_addr_d  = bus.req0_addr;
                        mem_wdata_d = bus.req0_wdata;
                        mem_be_d    = bus.req0_be;
                    end
                    mem_we_d = we_d;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (grant_id_q == PORT_DATA) begin
                        rsp1_valid_d = 1'b1;
                        rsp1_rdata_d = we_q ? '0 : bus.mem_rdata;
                    end else begin
                        rsp0_valid_d = 1'b1;
                        rsp0_rdata_d = we_q ? '0 : bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge areset) begin
        if (!areset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_DATA;
            grant_id_q   <= PORT_FETCH;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance A (MEM_LAT=2) against a cycle model, instance B
// (MEM_LAT=1) with a directed single read.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic clock  = 1'b0;
    logic areset = 1'b0;
    logic busy_a, busy_b;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    req_t        q0[$];
    req_t        q1[$];
    exp_t        sb[$];
    logic [31:0] exp_mem [logic [31:0]];
    logic [31:0] mem_a   [logic [31:0]];
    int          m_acc = -100;
    logic        m_lg  = 1'b1;
    req_t        m_req;
    logic [31:0] pa [0:LAT_A];
    logic [31:0] pb [0:LAT_B];

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ia ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) ib ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A)) dut_a (
        .clock  (clock),
        .areset (areset),
        .bus    (ia),
        .busy   (busy_a)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B)) dut_b (
        .clock  (clock),
        .areset (areset),
        .bus    (ib),
        .busy   (busy_b)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic req_t mk_req(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
        return r;
    endfunction

    // Requester driver for instance A: hold the queue head until it is accepted.
    initial begin
        logic a0, a1;
        ia.req0_valid = 1'b0; ia.req0_we = 1'b0; ia.req0_addr = '0; ia.req0_wdata = '0; ia.req0_be = '0;
        ia.req1_valid = 1'b0; ia.req1_we = 1'b0; ia.req1_addr = '0; ia.req1_wdata = '0; ia.req1_be = '0;
        forever begin
            @(negedge clock);
            a0 = areset && ia.req0_valid && ia.req0_ready;
            a1 = areset && ia.req1_valid && ia.req1_ready;
            @(posedge clock);
            #1;
            if (a0 && q0.size() > 0) q0.delete(0);
            if (a1 && q1.size() > 0) q1.delete(0);
            ia.req0_valid = (q0.size() > 0);
            if (q0.size() > 0) begin
                ia.req0_we = q0[0].we; ia.req0_addr = q0[0].addr;
                ia.req0_wdata = q0[0].wdata; ia.req0_be = q0[0].be;
            end
            ia.req1_valid = (q1.size() > 0);
            if (q1.size() > 0) begin
                ia.req1_we = q1[0].we; ia.req1_addr = q1[0].addr;
                ia.req1_wdata = q1[0].wdata; ia.req1_be = q1[0].be;
            end
        end
    end

    // Memory models: rdata appears MEM_LAT cycles after mem_en, garbage otherwise.
    initial begin
        logic [31:0] rd;
        for (int k = 0; k <= LAT_A; k++) pa[k] = '0;
        for (int k = 0; k <= LAT_B; k++) pb[k] = '0;
        ia.mem_rdata = '0;
        ib.mem_rdata = '0;
        forever begin
            @(negedge clock);
            for (int k = LAT_A; k > 0; k--) pa[k] = pa[k-1];
            for (int k = LAT_B; k > 0; k--) pb[k] = pb[k-1];
            if (ia.mem_en) begin
                rd = mem_a.exists(ia.mem_addr) ? mem_a[ia.mem_addr] : dflt(ia.mem_addr);
                pa[0] = rd;
                if (ia.mem_we) mem_a[ia.mem_addr] = merge(rd, ia.mem_wdata, ia.mem_be);
            end else begin
                pa[0] = 32'hBAD0_0000 ^ cyc;
            end
            pb[0] = ib.mem_en ? dflt(ib.mem_addr) : (32'hBAD1_0000 ^ cyc);
            ia.mem_rdata = pa[LAT_A];
            ib.mem_rdata = pb[LAT_B];
        end
    end

    // Cycle model and scoreboard for instance A.
    initial forever begin
        logic e_rdy0, e_rdy1, win;
        logic [31:0] old;
        req_t cur;
        exp_t e;
        @(negedge clock);
        if (!areset) begin
            m_acc = -100;
            m_lg  = 1'b1;
            sb.delete();
        end else begin
            e_rdy0 = 1'b0;
            e_rdy1 = 1'b0;
            if (cyc >= m_acc + LAT_A + 3 && (ia.req0_valid || ia.req1_valid)) begin
                win = (ia.req0_valid && ia.req1_valid) ? ~m_lg : ia.req1_valid;
                if (win) begin
                    e_rdy1 = 1'b1;
                    cur = mk_req(ia.req1_we, ia.req1_addr, ia.req1_wdata, ia.req1_be);
                end else begin
                    e_rdy0 = 1'b1;
                    cur = mk_req(ia.req0_we, ia.req0_addr, ia.req0_wdata, ia.req0_be);
                end
                old = exp_mem.exists(cur.addr) ? exp_mem[cur.addr] : dflt(cur.addr);
                if (cur.we) exp_mem[cur.addr] = merge(old, cur.wdata, cur.be);
                e.port  = win;
                e.rdata = cur.we ? 32'h0 : old;
                e.due   = cyc + LAT_A + 2;
                sb.push_back(e);
                m_acc = cyc;
                m_lg  = win;
                m_req = cur;
            end
            chk("a_rdy0", ia.req0_ready, e_rdy0);
            chk("a_rdy1", ia.req1_ready, e_rdy1);
            if (cyc == m_acc + 1) begin
                chk("a_issue_en", ia.mem_en, 1);
                chk("a_issue_we", ia.mem_we, m_req.we);
                chk("a_issue_addr", ia.mem_addr, m_req.addr);
                chk("a_issue_wdata", ia.mem_wdata, m_req.wdata);
                chk("a_issue_be", ia.mem_be, m_req.be);
            end else begin
                chk("a_mem_en_idle", ia.mem_en, 0);
                chk("a_mem_addr_idle", ia.mem_addr, 0);
            end
            chk("a_busy", busy_a, (cyc > m_acc) && (cyc <= m_acc + LAT_A + 2));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("a_rsp0_valid", ia.rsp0_valid, !sb[0].port);
                chk("a_rsp1_valid", ia.rsp1_valid, sb[0].port);
                chk("a_rsp_rdata", sb[0].port ? ia.rsp1_rdata : ia.rsp0_rdata, sb[0].rdata);
                sb.delete(0);
            end else begin
                chk("a_rsp0_quiet", ia.rsp0_valid, 0);
                chk("a_rsp1_quiet", ia.rsp1_valid, 0);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_mem_en"}, ia.mem_en, 0);
        chk({tag, "_mem_we"}, ia.mem_we, 0);
        chk({tag, "_mem_addr"}, ia.mem_addr, 0);
        chk({tag, "_mem_wdata"}, ia.mem_wdata, 0);
        chk({tag, "_mem_be"}, ia.mem_be, 0);
        chk({tag, "_rsp0_valid"}, ia.rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, ia.rsp1_valid, 0);
        chk({tag, "_rsp0_rdata"}, ia.rsp0_rdata, 0);
        chk({tag, "_rsp1_rdata"}, ia.rsp1_rdata, 0);
        chk({tag, "_busy_a"}, busy_a, 0);
        chk({tag, "_b_mem_en"}, ib.mem_en, 0);
        chk({tag, "_b_rsp0_rdata"}, ib.rsp0_rdata, 0);
        chk({tag, "_busy_b"}, busy_b, 0);
    endtask

    task automatic do_reset(input string tag);
        q0.delete();
        q1.delete();
        areset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset(tag);
        @(posedge clock);
        #3;
        areset = 1'b1;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || cyc < m_acc + LAT_A + 4)
               && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, "_drain_timeout"}, n < 300, 1);
    endtask

    initial begin
        int prev, n;
        ib.req0_valid = 1'b0; ib.req0_we = 1'b0; ib.req0_addr = '0; ib.req0_wdata = '0; ib.req0_be = '0;
        ib.req1_valid = 1'b0; ib.req1_we = 1'b0; ib.req1_addr = '0; ib.req1_wdata = '0; ib.req1_be = '0;
        exp_mem[32'h100] = 32'hDEAD_BEEF;
        mem_a[32'h100]   = 32'hDEAD_BEEF;

        do_reset("rst0");
        q0.push_back(mk_req(1'b0, 32'h100, 32'h0, 4'hF));
        wait_idle_a("single");

        do_reset("rst1");
        q0.push_back(mk_req(1'b0, 32'h200, 32'h0, 4'hF));
        q0.push_back(mk_req(1'b0, 32'h204, 32'h0, 4'hF));
        q1.push_back(mk_req(1'b0, 32'h300, 32'h0, 4'hF));
        q1.push_back(mk_req(1'b0, 32'h304, 32'h0, 4'hF));
        wait_idle_a("ties");

        q1.push_back(mk_req(1'b1, 32'h40, 32'h1234_5678, 4'b0011));
        q1.push_back(mk_req(1'b0, 32'h40, 32'h0, 4'hF));
        wait_idle_a("write");

        q0.push_back(mk_req(1'b0, 32'h600, 32'h0, 4'hF));
        q0.push_back(mk_req(1'b0, 32'h604, 32'h0, 4'hF));
        wait_idle_a("b2b");

        prev = m_acc;
        n = 0;
        q0.push_back(mk_req(1'b0, 32'h500, 32'h0, 4'hF));
        while (m_acc == prev && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("midrst_accept_timeout", n < 50, 1);
        @(posedge clock);
        #2;
        areset = 1'b0;
        #1;
        check_reset("midrst");
        do_reset("midrst_hold");
        q0.push_back(mk_req(1'b0, 32'h700, 32'h0, 4'hF));
        q1.push_back(mk_req(1'b0, 32'h704, 32'h0, 4'hF));
        wait_idle_a("post_rst_tie");

        // Instance B: single read at MEM_LAT=1, accepted in cycle T.
        @(posedge clock);
        #1;
        ib.req0_valid = 1'b1;
        ib.req0_addr  = 32'h80;
        ib.req0_be    = 4'hF;
        @(negedge clock);
        chk("b_rdy0_T", ib.req0_ready, 1);
        chk("b_rdy1_T", ib.req1_ready, 0);
        chk("b_busy_T", busy_b, 0);
        @(posedge clock);
        #1;
        ib.req0_valid = 1'b0;
        @(negedge clock);
        chk("b_mem_en_T1", ib.mem_en, 1);
        chk("b_mem_addr_T1", ib.mem_addr, 32'h80);
        chk("b_mem_we_T1", ib.mem_we, 0);
        chk("b_busy_T1", busy_b, 1);
        @(negedge clock);
        chk("b_mem_en_T2", ib.mem_en, 0);
        chk("b_rsp0_T2", ib.rsp0_valid, 0);
        chk("b_busy_T2", busy_b, 1);
        @(negedge clock);
        chk("b_rsp0_T3", ib.rsp0_valid, 1);
        chk("b_rdata_T3", ib.rsp0_rdata, dflt(32'h80));
        chk("b_rsp1_T3", ib.rsp1_valid, 0);
        chk("b_busy_T3", busy_b, 1);
        @(negedge clock);
        chk("b_rsp0_T4", ib.rsp0_valid, 0);
        chk("b_rdata_hold_T4", ib.rsp0_rdata, dflt(32'h80));
        chk("b_busy_T4", busy_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
